// File: rtl/morse_pkg.sv
// Shared types and sizes for the Morse key classifier.
package morse_pkg;

    localparam int unsigned MAX_SYMBOLS = 5;
    localparam int unsigned CODE_W      = 5;
    localparam int unsigned LEN_W       = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS     = 2'd1,
        GAP       = 2'd2,
        WORD_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer followed by a tick-based debounce of the key.
module morse_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 50,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_level
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] deb_cnt;

    // Bring the asynchronous key into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    // Toggle the level only after DEBOUNCE_TICKS consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            key_level <= 1'b0;
        end else if (tick) begin
            if (sync_q[1] != key_level) begin
                if (deb_cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    key_level <= ~key_level;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/morse_key_classifier.sv
// Classifies debounced key presses into dots/dashes and assembles letters.
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS   = 50,
    parameter int unsigned DASH_TICKS       = 2000,
    parameter int unsigned LETTER_GAP_TICKS = 4000,
    parameter int unsigned WORD_GAP_TICKS   = 10000,
    parameter int unsigned CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              key_in,
    output logic              key_level,
    output logic              sym_valid,
    output logic              sym_is_dash,
    output logic              letter_valid,
    output logic [CODE_W-1:0] letter_code,
    output logic [LEN_W-1:0]  letter_len,
    output logic              letter_err,
    output logic              word_gap
);

    state_t            state, state_n;
    logic              prev_level;
    logic              rise, fall;
    logic [CNT_W-1:0]  dur, dur_n, dur_inc;
    logic [CNT_W-1:0]  gap, gap_n, gap_inc;
    logic [CODE_W-1:0] code, code_n;
    logic [LEN_W-1:0]  len, len_n;
    logic              err, err_n;
    logic              is_dash;

    logic              sym_valid_n, sym_is_dash_n;
    logic              letter_valid_n, letter_err_n, word_gap_n;
    logic [CODE_W-1:0] letter_code_n;
    logic [LEN_W-1:0]  letter_len_n;

    morse_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .CNT_W         (CNT_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_in   (key_in),
        .key_level(key_level)
    );

    assign rise    = key_level & ~prev_level;
    assign fall    = ~key_level & prev_level;
    assign dur_inc = (dur == '1) ? dur : dur + CNT_W'(1);
    assign gap_inc = (gap == '1) ? gap : gap + CNT_W'(1);
    assign is_dash = (dur >= CNT_W'(DASH_TICKS));

    // State, duration counters, letter accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev_level   <= 1'b0;
            dur          <= '0;
            gap          <= '0;
            code         <= '0;
            len          <= '0;
            err          <= 1'b0;
            sym_valid    <= 1'b0;
            sym_is_dash  <= 1'b0;
            letter_valid <= 1'b0;
            letter_code  <= '0;
            letter_len   <= '0;
            letter_err   <= 1'b0;
            word_gap     <= 1'b0;
        end else begin
            state        <= state_n;
            prev_level   <= key_level;
            dur          <= dur_n;
            gap          <= gap_n;
            code         <= code_n;
            len          <= len_n;
            err          <= err_n;
            sym_valid    <= sym_valid_n;
            sym_is_dash  <= sym_is_dash_n;
            letter_valid <= letter_valid_n;
            letter_code  <= letter_code_n;
            letter_len   <= letter_len_n;
            letter_err   <= letter_err_n;
            word_gap     <= word_gap_n;
        end
    end

    // Next-state, counter and output decode; a threshold close and a new press can share a cycle.
    always_comb begin
        state_n        = state;
        dur_n          = dur;
        gap_n          = gap;
        code_n         = code;
        len_n          = len;
        err_n          = err;
        sym_valid_n    = 1'b0;
        sym_is_dash_n  = sym_is_dash;
        letter_valid_n = 1'b0;
        letter_code_n  = letter_code;
        letter_len_n   = letter_len;
        letter_err_n   = letter_err;
        word_gap_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESS;
                    dur_n   = '0;
                end
            end
            PRESS: begin
                if (tick) begin
                    dur_n = dur_inc;
                end
                if (fall) begin
                    sym_valid_n   = 1'b1;
                    sym_is_dash_n = is_dash;
                    if (len < LEN_W'(MAX_SYMBOLS)) begin
                        code_n = {code[CODE_W-2:0], is_dash};
                        len_n  = len + LEN_W'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = GAP;
                    gap_n   = '0;
                end
            end
            GAP: begin
                if (tick) begin
                    gap_n = gap_inc;
                    if (gap_inc == CNT_W'(LETTER_GAP_TICKS)) begin
                        letter_valid_n = 1'b1;
                        letter_code_n  = code;
                        letter_len_n   = len;
                        letter_err_n   = err;
                        code_n         = '0;
                        len_n          = '0;
                        err_n          = 1'b0;
                        state_n        = WORD_WAIT;
                    end
                end
                if (rise) begin
                    state_n = PRESS;
                    dur_n   = '0;
                end
            end
            WORD_WAIT: begin
                if (tick) begin
                    gap_n = gap_inc;
                    if (gap_inc == CNT_W'(WORD_GAP_TICKS)) begin
                        word_gap_n = 1'b1;
                        state_n    = IDLE;
                    end
                end
                if (rise) begin
                    state_n = PRESS;
                    dur_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier with shortened thresholds.
module tb_morse_key_classifier;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       key_in;
    logic       key_level;
    logic       sym_valid;
    logic       sym_is_dash;
    logic       letter_valid;
    logic [4:0] letter_code;
    logic [2:0] letter_len;
    logic       letter_err;
    logic       word_gap;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state
    int          cyc = 0;
    int          sym_cnt = 0;
    int          let_cnt = 0;
    int          word_cnt = 0;
    int          lat_err = 0;
    int          wid_err = 0;
    int          fall_cyc = 0;
    logic [15:0] sym_hist = '0;
    logic [4:0]  last_code = '0;
    logic [2:0]  last_len = '0;
    logic        last_err = 1'b0;
    logic        kl_d = 1'b0;
    logic        tick_d = 1'b0;
    logic        sv_d = 1'b0;
    logic        lv_d = 1'b0;
    logic        wg_d = 1'b0;

    // Expected running totals
    int e_sym = 0;
    int e_let = 0;
    int e_word = 0;
    int saved_let;

    morse_key_classifier #(
        .DEBOUNCE_TICKS  (2),
        .DASH_TICKS      (4),
        .LETTER_GAP_TICKS(6),
        .WORD_GAP_TICKS  (14),
        .CNT_W           (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .key_in      (key_in),
        .key_level   (key_level),
        .sym_valid   (sym_valid),
        .sym_is_dash (sym_is_dash),
        .letter_valid(letter_valid),
        .letter_code (letter_code),
        .letter_len  (letter_len),
        .letter_err  (letter_err),
        .word_gap    (word_gap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick strobe: one clk high out of every four.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Pulse capture, latency and width checks, sampled on the falling edge.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        kl_d   <= key_level;
        tick_d <= tick;
        sv_d   <= sym_valid;
        lv_d   <= letter_valid;
        wg_d   <= word_gap;
        if (!key_level && kl_d) fall_cyc <= cyc;
        if ((sym_valid && sv_d) || (letter_valid && lv_d) || (word_gap && wg_d))
            wid_err <= wid_err + 1;
        if (sym_valid) begin
            sym_cnt  <= sym_cnt + 1;
            sym_hist <= {sym_hist[14:0], sym_is_dash};
            if (cyc != fall_cyc + 1) lat_err <= lat_err + 1;
        end
        if (letter_valid) begin
            let_cnt   <= let_cnt + 1;
            last_code <= letter_code;
            last_len  <= letter_len;
            last_err  <= letter_err;
            if (!tick_d) lat_err <= lat_err + 1;
        end
        if (word_gap) begin
            word_cnt <= word_cnt + 1;
            if (!tick_d) lat_err <= lat_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past n tick edges; inputs change just after the last one.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick);
        end
        #2;
    endtask

    task automatic press(input int n);
        key_in = 1'b1;
        wait_ticks(n);
        key_in = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_sym"},  32'(sym_cnt),  32'(e_sym));
        check({tag, "_let"},  32'(let_cnt),  32'(e_let));
        check({tag, "_word"}, 32'(word_cnt), 32'(e_word));
    endtask

    task automatic check_letter(input string tag, input logic [4:0] code,
                                input logic [2:0] len, input logic err);
        check({tag, "_code"}, 32'(last_code), 32'(code));
        check({tag, "_len"},  32'(last_len),  32'(len));
        check({tag, "_err"},  32'(last_err),  32'(err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_level"}, 32'(key_level), 32'd0);
        check({tag, "_pulses"}, 32'({sym_valid, letter_valid, word_gap}), 32'd0);
        check({tag, "_sym_is_dash"}, 32'(sym_is_dash), 32'd0);
        check({tag, "_letter"}, 32'({letter_code, letter_len, letter_err}), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        wait_ticks(2);

        // Single dot -> "E", then a word gap
        press(2);
        wait_ticks(20);
        e_sym++; e_let++; e_word++;
        check_counts("e_letter");
        check("e_sym_type", 32'(sym_hist[0]), 32'd0);
        check_letter("e_letter", 5'b00000, 3'd1, 1'b0);

        // Dot/dash boundary: 3 ticks is a dot, 4 ticks is a dash
        press(3);
        wait_ticks(20);
        e_sym++; e_let++; e_word++;
        check("dot3_type", 32'(sym_hist[0]), 32'd0);
        press(4);
        wait_ticks(20);
        e_sym++; e_let++; e_word++;
        check("dash4_type", 32'(sym_hist[0]), 32'd1);
        check_letter("t_letter", 5'b00001, 3'd1, 1'b0);
        check_counts("boundary");

        // dash dot dash -> "K", letter before the word gap
        press(6); wait_ticks(2);
        press(2); wait_ticks(2);
        press(6);
        wait_ticks(10);
        e_sym += 3; e_let++;
        check_counts("k_letter");
        check("k_syms", 32'(sym_hist[2:0]), 32'(3'b101));
        check_letter("k_letter", 5'b00101, 3'd3, 1'b0);
        wait_ticks(10);
        e_word++;
        check("k_word", 32'(word_cnt), 32'(e_word));

        // One-tick glitch is filtered; a held key rises
        press(1);
        wait_ticks(6);
        check("glitch_level", 32'(key_level), 32'd0);
        check_counts("glitch");
        key_in = 1'b1;
        wait_ticks(3);
        check("held_level", 32'(key_level), 32'd1);
        key_in = 1'b0;
        wait_ticks(20);
        e_sym++; e_let++; e_word++;

        // Six dots overflow the letter
        for (int i = 0; i < 6; i++) begin
            press(2);
            wait_ticks(2);
        end
        wait_ticks(18);
        e_sym += 6; e_let++; e_word++;
        check_counts("overflow");
        check_letter("overflow", 5'b00000, 3'd5, 1'b1);
        press(4);
        wait_ticks(20);
        e_sym++; e_let++; e_word++;
        check_letter("after_overflow", 5'b00001, 3'd1, 1'b0);

        // Reset mid-press discards the pending letter
        press(2); wait_ticks(2);
        press(2); wait_ticks(2);
        key_in = 1'b1;
        wait_ticks(5);
        e_sym += 2;
        rst    = 1'b1;
        key_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        saved_let = let_cnt;
        wait_ticks(20);
        check("no_letter_after_reset", 32'(let_cnt), 32'(saved_let));
        check_counts("mid_reset");
        press(4);
        wait_ticks(20);
        e_sym++; e_let++; e_word++;
        check_letter("post_reset", 5'b00001, 3'd1, 1'b0);

        // Re-press on exactly the letter-gap tick
        press(2);
        wait_ticks(6);
        key_in = 1'b1;
        wait_ticks(4);
        e_sym++; e_let++;
        check_counts("coincide_first");
        check_letter("coincide_first", 5'b00000, 3'd1, 1'b0);
        key_in = 1'b0;
        wait_ticks(20);
        e_sym++; e_let++; e_word++;
        check_letter("coincide_second", 5'b00001, 3'd1, 1'b0);
        check_counts("coincide_end");

        check("latency", 32'(lat_err), 32'd0);
        check("pulse_width", 32'(wid_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
